// File: rtl/alu_pkg.sv
// Shared ALU definitions: add/subtract opcode encodings and the carry-in rule used at operand accept.
package alu_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_ADC = 2'b01,
        OP_SUB = 2'b10,
        OP_SBB = 2'b11
    } op_t;

    // Subtraction is a + ~b + 1, so SBB's borrow-in enters as an inverted carry.
    function automatic logic initialCarry(input op_t op, input logic cin);
        logic carry;
        case (op)
            OP_ADD:  carry = 1'b0;
            OP_ADC:  carry = cin;
            OP_SUB:  carry = 1'b1;
            default: carry = ~cin;
        endcase
        return carry;
    endfunction

endpackage

// File: rtl/addsub_slice.sv
// Stateless N-bit chunk adder; also reports the carry into its MSB so the top chunk can derive signed overflow.
module addsub_slice #(
    parameter int N = 8
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic         i_cin,
    output logic [N-1:0] o_sum,
    output logic         o_cout,
    output logic         o_msbCarry
);
    logic [N:0] w_full;

    assign w_full     = {1'b0, i_a} + {1'b0, i_b} + {{N{1'b0}}, i_cin};
    assign o_sum      = w_full[N-1:0];
    assign o_cout     = w_full[N];
    assign o_msbCarry = i_a[N-1] ^ i_b[N-1] ^ w_full[N-1];
endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined WIDTH-bit add/subtract: one CHUNK-bit slice per stage with the carry registered between stages.
module pipelined_addsub
    import alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);
    localparam int CHUNK = WIDTH / STAGES;

    logic             w_en;
    logic [WIDTH-1:0] w_inA     [STAGES];
    logic [WIDTH-1:0] w_inB     [STAGES];
    logic [WIDTH-1:0] w_inSum   [STAGES];
    logic             w_inCarry [STAGES];
    logic             w_inZero  [STAGES];
    logic             w_inValid [STAGES];
    logic             w_msbCarry[STAGES];

    // A held result blocks every slot, so the whole pipe advances or freezes together.
    assign w_en     = !(out_valid && !out_ready);
    assign in_ready = w_en;

    assign w_inA[0]     = a;
    assign w_inB[0]     = op[1] ? ~b : b;
    assign w_inSum[0]   = '0;
    assign w_inCarry[0] = initialCarry(op_t'(op), cin);
    assign w_inZero[0]  = 1'b1;
    assign w_inValid[0] = in_valid;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [CHUNK-1:0] w_chunkSum;
        logic             w_chunkCout;
        logic             r_valid;
        logic             r_carry;
        logic             r_zero;
        logic [WIDTH-1:0] r_sum;

        addsub_slice #(.N(CHUNK)) u_slice (
            .i_a       (w_inA[k][k*CHUNK +: CHUNK]),
            .i_b       (w_inB[k][k*CHUNK +: CHUNK]),
            .i_cin     (w_inCarry[k]),
            .o_sum     (w_chunkSum),
            .o_cout    (w_chunkCout),
            .o_msbCarry(w_msbCarry[k])
        );

        // Result bits above this chunk are still zero, so OR-ing the new chunk in builds the sum.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_valid <= 1'b0;
                r_carry <= 1'b0;
                r_zero  <= 1'b0;
                r_sum   <= '0;
            end else if (w_en) begin
                r_valid <= w_inValid[k];
                r_carry <= w_chunkCout;
                r_zero  <= w_inZero[k] && (w_chunkSum == '0);
                r_sum   <= w_inSum[k] | (WIDTH'(w_chunkSum) << (k*CHUNK));
            end
        end

        if (k < STAGES-1) begin : g_pass
            logic [WIDTH-1:0] r_a;
            logic [WIDTH-1:0] r_b;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_en) begin
                    r_a <= w_inA[k];
                    r_b <= w_inB[k];
                end
            end

            assign w_inA[k+1]     = r_a;
            assign w_inB[k+1]     = r_b;
            assign w_inSum[k+1]   = r_sum;
            assign w_inCarry[k+1] = r_carry;
            assign w_inZero[k+1]  = r_zero;
            assign w_inValid[k+1] = r_valid;
        end else begin : g_last
            logic r_ovf;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_ovf <= 1'b0;
                end else if (w_en) begin
                    r_ovf <= w_chunkCout ^ w_msbCarry[k];
                end
            end

            assign out_valid = r_valid;
            assign sum       = r_sum;
            assign cout      = r_carry;
            assign ovf       = r_ovf;
            assign zero      = r_zero;
            assign neg       = r_sum[WIDTH-1];
        end
    end
endmodule
